// File: rtl/aes128_enc_sequencer.sv
// rtl/aes128_enc_sequencer.sv - iterative AES-128 encrypt engine, one round per clock
module aes128_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Forward S-box table, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n sits at bit 8*(255-n) = 8*~n.
  assign out_o = SBOX[{~in_i, 3'b000} +: 8];

endmodule

module aes128_enc_sequencer #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [32*NK-1:0]    in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic [127:0]        out_key,
  output logic                busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;

  logic [7:0]   sub_b [16];
  logic [7:0]   sr_b  [16];
  logic [7:0]   mc_b  [16];
  logic [7:0]   ksub_b [4];
  logic [31:0]  rot_w;
  logic [31:0]  nk_w0, nk_w1, nk_w2, nk_w3;
  logic [127:0] next_key;
  logic [127:0] rnd_state;
  logic         last_round;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 16 state S-boxes plus 4 key-schedule S-boxes on RotWord(w3).
  assign rot_w = {key_q[23:0], key_q[31:24]};

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes128_sbox u_sbox (.in_i(state_q[127-8*i -: 8]), .out_o(sub_b[i]));
  end

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes128_sbox u_sbox (.in_i(rot_w[31-8*j -: 8]), .out_o(ksub_b[j]));
  end

  assign last_round = (round_q == 4'(NR));

  // On-the-fly key expansion for the round being computed.
  always_comb begin
    nk_w0    = key_q[127:96] ^ {ksub_b[0], ksub_b[1], ksub_b[2], ksub_b[3]} ^ {rcon_q, 24'h0};
    nk_w1    = key_q[95:64] ^ nk_w0;
    nk_w2    = key_q[63:32] ^ nk_w1;
    nk_w3    = key_q[31:0]  ^ nk_w2;
    next_key = {nk_w0, nk_w1, nk_w2, nk_w3};
  end

  // ShiftRows, MixColumns (skipped in the last round) and AddRoundKey.
  always_comb begin
    rnd_state = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_b[4*c+r] = sub_b[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_b[4*c]   = xt(sr_b[4*c]) ^ xt(sr_b[4*c+1]) ^ sr_b[4*c+1] ^ sr_b[4*c+2] ^ sr_b[4*c+3];
      mc_b[4*c+1] = sr_b[4*c] ^ xt(sr_b[4*c+1]) ^ xt(sr_b[4*c+2]) ^ sr_b[4*c+2] ^ sr_b[4*c+3];
      mc_b[4*c+2] = sr_b[4*c] ^ sr_b[4*c+1] ^ xt(sr_b[4*c+2]) ^ xt(sr_b[4*c+3]) ^ sr_b[4*c+3];
      mc_b[4*c+3] = xt(sr_b[4*c]) ^ sr_b[4*c] ^ sr_b[4*c+1] ^ sr_b[4*c+2] ^ xt(sr_b[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      rnd_state[127-8*i -: 8] = (last_round ? sr_b[i] : mc_b[i]) ^ next_key[127-8*i -: 8];
    end
  end

  // Sequencer: load on accept, one round per cycle, hold result until taken.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = in_data ^ in_key;
          key_d   = in_key;
          round_d = 4'd1;
          rcon_d  = 8'h01;
          fsm_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        state_d = rnd_state;
        key_d   = next_key;
        rcon_d  = xt(rcon_q);
        round_d = round_q + 4'd1;
        if (last_round) fsm_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset that discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  // Result buses read zero outside DONE so intermediate rounds never show.
  assign in_ready  = (fsm_q == S_IDLE) && !rst;
  assign busy      = (fsm_q == S_ROUND);
  assign out_valid = (fsm_q == S_DONE);
  assign out_data  = out_valid ? state_q : '0;
  assign out_key   = out_valid ? key_q   : '0;

endmodule
